fifo_parity_tx: RTL

Serial transmitter that drains the team's synchronous FIFO from its read side and sends each word as an asynchronous serial frame: start bit, data LSB-first, parity bit, stop bit. It sits between the FIFO and the chip-level serial pin, and is the consumer for the FIFO's `rd_en`/`dout`/`empty` interface. It generates the parity bit that the downstream parity checker validates.

---
 rtl/fifo_parity_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_parity_tx.sv
// fifo_parity_tx
//
// Serial transmitter that drains a synchronous FIFO from its read side. Each
// popped word goes out as one frame: start bit (0), WIDTH data bits LSB first,
// an optional parity bit, and a stop bit (1). Every bit lasts CLKS_PER_BIT
// cycles.
//
// Build option: define TX_PARITY_EN to include the parity bit in each frame.
// Without it, frames are WIDTH+2 bits, PARITY_ODD has no effect, and no parity
// logic is built.
//
// Parameters:
//   WIDTH         data word width; must match the FIFO width
//   CLKS_PER_BIT  clock cycles per serial bit, >= 2
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_dout     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    FIFO pop strobe (combinational, IDLE only)
//   tx_enable     allows new words to be popped; a running frame always completes
//   tx            registered serial line, idles high
//   busy          high whenever the state is not IDLE
//   frame_done    one-cycle pulse in the IDLE cycle after a stop bit
//   frames_sent   count of completed frames, wraps at 16 bits
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high; pops a word when enabled and the FIFO is not empty
// LOAD   | one cycle; captures fifo_dout and the parity of the word
// START  | start bit (0)
// DATA   | WIDTH data bits, LSB first
// PARITY | parity bit (only reachable with TX_PARITY_EN)
// STOP   | stop bit (1); returns to IDLE and counts the frame

module fifo_parity_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             tx_enable,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frames_sent
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      frames_sent_q, frames_sent_d;
    logic             parity_bit;
    logic             bit_end;

`ifdef TX_PARITY_EN
    logic parity_q, parity_d;

    // Parity is taken from the FIFO data in the same cycle it is captured.
    always_comb begin
        parity_d = parity_q;
        if (state_q == S_LOAD) begin
            parity_d = (^fifo_dout) ^ (PARITY_ODD != 0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_bit = parity_q;
`else
    logic unused_parity_odd;

    assign parity_bit        = 1'b1;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        frame_done_d  = 1'b0;
        frames_sent_d = frames_sent_q;
        fifo_rd_en    = 1'b0;
        bit_end       = (cyc_q == CYC_LAST);

        case (state_q)
            S_IDLE: begin
                // reset_n in the term keeps the pop strobe low while reset is held.
                fifo_rd_en = tx_enable & ~fifo_empty & reset_n;
                if (fifo_rd_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d = fifo_dout;
                cyc_d   = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                cyc_d = bit_end ? '0 : cyc_q + CW'(1);
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cyc_d = bit_end ? '0 : cyc_q + CW'(1);
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                cyc_d = bit_end ? '0 : cyc_q + CW'(1);
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                cyc_d = bit_end ? '0 : cyc_q + CW'(1);
                if (bit_end) begin
                    state_d       = S_IDLE;
                    frame_done_d  = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered, so it is computed from the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cyc_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            tx_q          <= 1'b1;
            frame_done_q  <= 1'b0;
            frames_sent_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;

endmodule
